ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the
//  keyboard over the shared open-drain PS2_clk/PS2_data lines. Companion to the keyboard receiver;
//  asserts rx_inhibit so the receiver ignores line activity while a transmission is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  5000     system_clk cycles PS2_clk is held low before request (100us @ 50MHz)
//  TIMEOUT_CYCLES  750000   max cycles from clock release to device ACK (15ms @ 50MHz)
//  SYNC_STAGES     2        flip-flop stages on PS2_clk_in/PS2_data_in (>=2)
// PORTS
//  system_clk   in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-low reset
//  tx_data      in   8  command byte to send
//  tx_valid     in   1  request; byte accepted on a cycle with tx_valid & tx_ready
//  tx_ready     out  1  high only in IDLE
//  tx_done      out  1  one-cycle pulse at end of every accepted transfer (success or failure)
//  tx_error     out  1  qualifies tx_done: 1 = no ACK or timeout
//  rx_inhibit   out  1  high whenever state != IDLE
//  PS2_clk_in   in   1  raw PS/2 clock line (asynchronous)
//  PS2_data_in  in   1  raw PS/2 data line (asynchronous)
//  PS2_clk_oe   out  1  1 = pull PS2_clk low; 0 = release (pad is open-drain)
//  PS2_data_oe  out  1  1 = pull PS2_data low; 0 = release
// BEHAVIOUR
//  Reset (reset==0 at a posedge): state IDLE; tx_ready=1; all other outputs 0; both lines released
//   on the same edge, including mid-transfer. No partial byte is resumed.
//  Inputs synchronized, then ps2_fall = one-cycle pulse on synchronized 1->0 of PS2_clk.
//  Accept: latch tx_data, shift = {1'b1 stop, ~^tx_data odd parity, tx_data}; bit counter = 0.
//  States:
//   IDLE     -> INHIBIT on accept.
//   INHIBIT  clk_oe=1 for INHIBIT_CYCLES cycles -> REQ.
//   REQ      clk_oe=1, data_oe=1 for one cycle (start bit 0) -> SEND; ps2_fall ignored here.
//   SEND     clk_oe=0. On each ps2_fall: data_oe = ~shift[cnt], cnt++. Falls 1-8 put data bits
//            LSB first, fall 9 parity, fall 10 stop (data_oe=0) -> ACK.
//   ACK      on next ps2_fall sample synchronized data: 0 -> WAIT_IDLE ok, 1 -> WAIT_IDLE err.
//   WAIT_IDLE wait until synchronized clk==1 and data==1 -> IDLE, pulse tx_done (+tx_error if err).
//  Timeout: counter cleared on REQ->SEND, runs through SEND/ACK/WAIT_IDLE; reaching TIMEOUT_CYCLES
//   releases both lines, pulses tx_done=1 & tx_error=1, -> IDLE. Timeout wins over a same-cycle ps2_fall.
//  tx_valid while busy is ignored (no queuing); tx_data changes after accept have no effect.
//  tx_done and tx_ready never high together on the same cycle; tx_ready rises the cycle after tx_done.
//  Counter widths: $clog2 of their parameter + 1; bit counter 4 bits, saturates at 11.
//  Latency accept->first clk_oe: 1 cycle. Device clock rate is not assumed; only edges are used.
// STRUCTURE
//  Package ps2_pkg: state encoding (IDLE,INHIBIT,REQ,SEND,ACK,WAIT_IDLE), PS2_FRAME_BITS=11,
//   command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
//  Sub-module ps2_line_sync: SYNC_STAGES synchronizers + falling-edge pulse; reused by the receiver.
// TESTING  (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=400; device BFM clocks at 20-cycle period)
//  1 send 8'hED -> clk_oe high 10 cycles, REQ 1 cycle, data bits on falls 1-10 = 1,0,1,1,0,1,1,1,
//    parity 1, stop 1; BFM ACKs -> tx_done=1, tx_error=0, tx_ready back next cycle.
//  2 send 8'hF4 -> bits 0,0,1,0,1,1,1,1, parity 0; BFM verifies parity and frame, ACKs.
//  3 BFM never drives clock after REQ -> exactly 400 cycles later tx_done=1, tx_error=1, lines released.
//  4 BFM leaves data high at fall 11 -> tx_done=1, tx_error=1 after lines idle.
//  5 tx_valid pulsed with 8'h00 during SEND of 8'hED -> ignored; only 8'hED appears on the line.
//  6 reset low during fall 5 of SEND -> next edge PS2_clk_oe=PS2_data_oe=0, tx_ready=1, no tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
//  Shared definitions for the PS/2 host transmitter and its companion receiver:
//  FSM state encoding, frame geometry, common keyboard command bytes and the
//  PS/2 odd-parity helper.
// -----------------------------------------------------------------------------
package ps2_pkg;

  // FSM state encoding, kept as plain constants so legacy code can compare
  // against raw 3-bit values.
  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_REQ       = 3'd2;
  localparam ps2_state_t ST_SEND      = 3'd3;
  localparam ps2_state_t ST_ACK       = 3'd4;
  localparam ps2_state_t ST_WAIT_IDLE = 3'd5;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Common host-to-keyboard commands.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the parity bit makes the count of ones in
  // data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_if
//  Command handshake between a client and the PS/2 host transmitter.
//   tx_data  : command byte to send
//   tx_valid : request; byte taken on a cycle with tx_valid & tx_ready
//   tx_ready : transmitter idle and able to accept
//   tx_done  : one-cycle pulse at the end of every accepted transfer
//   tx_error : qualifies tx_done; 1 = no ACK from the device or timeout
//  master = client issuing commands, slave = the transmitter.
// -----------------------------------------------------------------------------
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_error
  );

endinterface

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
//  Brings the raw, asynchronous PS/2 clock and data lines into the system_clk
//  domain and produces a one-cycle pulse on each synchronized 1->0 transition
//  of the PS/2 clock. Shared by the host transmitter and the receiver.
//  Ports:
//   system_clk   : system clock
//   reset        : synchronous, active-low reset
//   ps2_clk_raw  : raw PS/2 clock line
//   ps2_data_raw : raw PS/2 data line
//   ps2_clk_s    : synchronized PS/2 clock
//   ps2_data_s   : synchronized PS/2 data (same latency as ps2_clk_s)
//   ps2_fall     : one-cycle pulse on synchronized PS/2 clock falling edge
// -----------------------------------------------------------------------------
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic system_clk,
  input  logic reset,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic ps2_clk_s,
  output logic ps2_data_s,
  output logic ps2_fall
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] data_pipe;
  logic                   clk_prev;

  // Idle PS/2 lines float high, so the chains reset to 1 to avoid a
  // spurious falling edge right after reset.
  // NOTE: flops are written with non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      clk_pipe  <= '1;
      data_pipe <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], ps2_clk_raw};
      data_pipe <= {data_pipe[SYNC_STAGES-2:0], ps2_data_raw};
      clk_prev  <= clk_pipe[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s  = clk_pipe[SYNC_STAGES-1];
  assign ps2_data_s = data_pipe[SYNC_STAGES-1];
  assign ps2_fall   = clk_prev & ~clk_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//  Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//  over the shared open-drain PS2_clk / PS2_data lines: inhibits the clock,
//  issues the request-to-send start bit, shifts data/parity/stop out on the
//  device's falling clock edges and checks the device ACK.
//  Ports:
//   system_clk  : system clock, all logic on posedge
//   reset       : synchronous, active-low reset
//   tx          : command handshake (slave side of ps2_host_tx_if)
//   rx_inhibit  : high whenever a transfer is in progress, so the companion
//                 receiver ignores line activity
//   PS2_clk_in  : raw PS/2 clock line
//   PS2_data_in : raw PS/2 data line
//   PS2_clk_oe  : 1 = pull PS2_clk low, 0 = release
//   PS2_data_oe : 1 = pull PS2_data low, 0 = release
// -----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          system_clk,
  input  logic          reset,
  ps2_host_tx_if.slave  tx,
  output logic          rx_inhibit,
  input  logic          PS2_clk_in,
  input  logic          PS2_data_in,
  output logic          PS2_clk_oe,
  output logic          PS2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // Index of the last shifted bit (stop) and saturation value of bit_cnt.
  localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 2);
  localparam logic [3:0] BIT_MAX  = 4'(PS2_FRAME_BITS);

  ps2_state_t       state;
  logic [9:0]       shift;      // {stop, parity, data[7:0]}
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             data_oe;
  logic             err_q;      // device did not ACK

  logic ps2_clk_s;
  logic ps2_data_s;
  logic ps2_fall;

  logic accept;
  logic timeout_hit;
  logic line_idle_done;

  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .system_clk   (system_clk),
    .reset        (reset),
    .ps2_clk_raw  (PS2_clk_in),
    .ps2_data_raw (PS2_data_in),
    .ps2_clk_s    (ps2_clk_s),
    .ps2_data_s   (ps2_data_s),
    .ps2_fall     (ps2_fall)
  );

  assign accept = tx.tx_valid && (state == ST_IDLE);

  // Timeout covers everything after the host releases the clock; it fires on
  // the last counted cycle so the transfer ends exactly TIMEOUT_CYCLES cycles
  // after the request cycle.
  assign timeout_hit = ((state == ST_SEND) || (state == ST_ACK) ||
                        (state == ST_WAIT_IDLE)) && (to_cnt == TO_LAST);

  // Both lines back high after the ACK bit: transfer complete.
  assign line_idle_done = (state == ST_WAIT_IDLE) && ps2_clk_s && ps2_data_s;

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      data_oe <= 1'b0;
      err_q   <= 1'b0;
    end else if (timeout_hit) begin
      // Timeout takes priority over any same-cycle PS/2 clock edge.
      state   <= ST_IDLE;
      data_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift   <= {1'b1, ps2_odd_parity(tx.tx_data), tx.tx_data};
            bit_cnt <= '0;
            inh_cnt <= '0;
            err_q   <= 1'b0;
            state   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            data_oe <= 1'b1;     // start bit
            state   <= ST_REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        ST_REQ: begin
          // Device clock edges are ignored here; the clock is still ours.
          to_cnt <= '0;
          state  <= ST_SEND;
        end

        ST_SEND: begin
          to_cnt <= to_cnt + 1'b1;
          if (ps2_fall) begin
            data_oe <= ~shift[bit_cnt];
            if (bit_cnt != BIT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_cnt == BIT_LAST) begin
              state <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          to_cnt <= to_cnt + 1'b1;
          if (ps2_fall) begin
            err_q <= ps2_data_s;   // device pulls data low to ACK
            state <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          to_cnt <= to_cnt + 1'b1;
          if (line_idle_done) begin
            data_oe <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          data_oe <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // tx_done is decoded on the last busy cycle, so tx_ready (IDLE) rises on the
  // following cycle and the two are never high together.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    tx.tx_done  = 1'b0;
    tx.tx_error = 1'b0;
    if (timeout_hit) begin
      tx.tx_done  = 1'b1;
      tx.tx_error = 1'b1;
    end else if (line_idle_done) begin
      tx.tx_done  = 1'b1;
      tx.tx_error = err_q;
    end
  end

  assign tx.tx_ready  = (state == ST_IDLE);
  assign rx_inhibit   = (state != ST_IDLE);
  assign PS2_clk_oe   = (state == ST_INHIBIT) || (state == ST_REQ);
  assign PS2_data_oe  = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//  Directed bench for ps2_host_tx with a PS/2 device model on the open-drain
//  lines. Each issued command pushes its expected outcome into a scoreboard;
//  a monitor pops and compares whenever the DUT pulses tx_done.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 10;
  localparam int TO  = 400;

  logic system_clk = 1'b0;
  logic reset      = 1'b0;
  always #5 system_clk = ~system_clk;

  ps2_host_tx_if tx_if ();

  logic rx_inhibit;
  logic PS2_clk_oe;
  logic PS2_data_oe;
  logic PS2_clk_in;
  logic PS2_data_in;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  // Open-drain wired-AND of host and device pull-downs.
  assign PS2_clk_in  = ~(PS2_clk_oe  | dev_clk_low);
  assign PS2_data_in = ~(PS2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .system_clk  (system_clk),
    .reset       (reset),
    .tx          (tx_if.slave),
    .rx_inhibit  (rx_inhibit),
    .PS2_clk_in  (PS2_clk_in),
    .PS2_data_in (PS2_data_in),
    .PS2_clk_oe  (PS2_clk_oe),
    .PS2_data_oe (PS2_data_oe)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    string       name;
    logic        err;
    logic        chk_frame;
    logic [10:0] frame;     // {stop, parity, data[7:0], start}
  } exp_t;

  exp_t        sb_q[$];
  logic [10:0] bfm_frame = '0;
  logic        prev_done = 1'b0;

  always @(negedge system_clk) begin
    exp_t e;
    if (prev_done) check("ready_after_done", 32'(tx_if.tx_ready), 32'd1);
    if (tx_if.tx_done) begin
      check("done_not_with_ready", 32'(tx_if.tx_ready), 32'd0);
      check("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.name, "_error"}, 32'(tx_if.tx_error), 32'(e.err));
        if (e.chk_frame) check({e.name, "_frame"}, 32'(bfm_frame), 32'(e.frame));
      end
    end
    prev_done = tx_if.tx_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input string name, input logic [7:0] b, input logic err,
                       input logic chk, input logic [10:0] frame, input logic push);
    exp_t e;
    @(negedge system_clk);
    check({name, "_ready_before"}, 32'(tx_if.tx_ready), 32'd1);
    if (push) begin
      e.name = name; e.err = err; e.chk_frame = chk; e.frame = frame;
      sb_q.push_back(e);
    end
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge system_clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h55;   // later changes must not matter
  endtask

  // Called on the first sample after accept; returns on the first SEND sample.
  task automatic check_request(input string name);
    int inh = 0;
    int req = 0;
    int g   = 0;
    check({name, "_clk_oe_latency"}, 32'(PS2_clk_oe), 32'd1);
    check({name, "_busy"}, 32'({tx_if.tx_ready, rx_inhibit}), 32'b01);
    while (PS2_clk_oe && !PS2_data_oe && g < 100) begin
      inh++; g++; @(negedge system_clk);
    end
    while (PS2_clk_oe && PS2_data_oe && g < 100) begin
      req++; g++; @(negedge system_clk);
    end
    check({name, "_inhibit_len"}, 32'(inh), 32'(INH));
    check({name, "_req_len"}, 32'(req), 32'd1);
    check({name, "_send_lines"}, 32'({PS2_clk_oe, PS2_data_oe}), 32'b01);
  endtask

  // One device clock pulse: 10 cycles low, 10 high; data sampled mid-high.
  task automatic dev_pulse(output logic s);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge system_clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge system_clk);
    s = PS2_data_in;
    repeat (5) @(negedge system_clk);
  endtask

  // Device clocks the 10 host bits in, then answers with or without ACK.
  task automatic bfm_run(input logic ack);
    logic [10:0] f;
    logic        s;
    repeat (5) @(negedge system_clk);
    f[0] = PS2_data_in;                  // start bit held by host
    for (int i = 1; i <= 10; i++) begin
      dev_pulse(s);
      f[i] = s;
    end
    bfm_frame = f;
    dev_data_low = ack;
    repeat (5) @(negedge system_clk);
    dev_pulse(s);                        // fall 11: host samples ACK
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (!tx_if.tx_ready && g < 600) begin
      @(negedge system_clk); g++;
    end
    check({name, "_back_idle"}, 32'(tx_if.tx_ready), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int   k;
    logic s;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    repeat (3) @(negedge system_clk);
    check("reset_ready", 32'(tx_if.tx_ready), 32'd1);
    check("reset_outputs", 32'({tx_if.tx_done, tx_if.tx_error, rx_inhibit,
                                PS2_clk_oe, PS2_data_oe}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge system_clk);

    // 1: set-LEDs with ACK. ED bits LSB first 1,0,1,1,0,1,1,1; parity 1.
    issue("ed", PS2_CMD_SET_LEDS, 1'b0, 1'b1, 11'b1_1_11101101_0, 1'b1);
    check_request("ed");
    bfm_run(1'b1);
    wait_idle("ed");

    // 2: enable with ACK. F4 has five ones -> parity 0.
    issue("f4", PS2_CMD_ENABLE, 1'b0, 1'b1, 11'b1_0_11110100_0, 1'b1);
    check_request("f4");
    bfm_run(1'b1);
    wait_idle("f4");

    // 5: tx_valid with 8'h00 during SEND of ED must be ignored.
    issue("busy", PS2_CMD_SET_LEDS, 1'b0, 1'b1, 11'b1_1_11101101_0, 1'b1);
    check_request("busy");
    fork
      begin
        repeat (60) @(negedge system_clk);
        check("busy_ready_low", 32'(tx_if.tx_ready), 32'd0);
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b1;
        @(negedge system_clk);
        tx_if.tx_valid = 1'b0;
      end
    join_none
    bfm_run(1'b1);
    wait_idle("busy");
    repeat (20) @(negedge system_clk);
    check("busy_no_second_xfer", 32'({PS2_clk_oe, rx_inhibit}), 32'd0);

    // 4: device never ACKs (data high at fall 11). FF -> parity 1.
    issue("nack", PS2_CMD_RESET, 1'b1, 1'b1, 11'b1_1_11111111_0, 1'b1);
    check_request("nack");
    bfm_run(1'b0);
    wait_idle("nack");

    // 3: device silent after REQ -> timeout 400 cycles after the REQ cycle.
    issue("tmo", PS2_CMD_ENABLE, 1'b1, 1'b0, 11'd0, 1'b1);
    check_request("tmo");
    k = 1;
    while (!tx_if.tx_done && k < 1000) begin
      @(negedge system_clk); k++;
    end
    check("tmo_latency", 32'(k), 32'(TO));
    @(negedge system_clk);
    check("tmo_lines_released", 32'({PS2_clk_oe, PS2_data_oe, tx_if.tx_ready}), 32'b001);

    // 6: reset during fall 5 of SEND releases lines on the next edge.
    issue("rst", PS2_CMD_SET_LEDS, 1'b0, 1'b0, 11'd0, 1'b0);
    check_request("rst");
    repeat (5) @(negedge system_clk);
    for (int i = 1; i <= 4; i++) dev_pulse(s);
    dev_clk_low = 1'b1;
    repeat (4) @(negedge system_clk);
    check("rst_pre_busy", 32'(rx_inhibit), 32'd1);
    reset = 1'b0;
    @(posedge system_clk);
    #1;
    check("rst_lines", 32'({PS2_clk_oe, PS2_data_oe}), 32'd0);
    check("rst_ready_no_done", 32'({tx_if.tx_ready, tx_if.tx_done}), 32'b10);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge system_clk);
    reset = 1'b1;
    repeat (50) @(negedge system_clk);
    check("rst_no_resume", 32'({PS2_clk_oe, PS2_data_oe, rx_inhibit}), 32'd0);

    repeat (5) @(negedge system_clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
